filter_csr_bank: RTL and testbench

Second-generation configuration/status register bank for the N-channel input filter array, sitting between the byte-wide register access interface and the filter channels. Per-channel control fields are kept unchanged. New in this generation:
- write-1-to-clear interrupt status
- sticky overflow flags
- per-channel interrupt masks
- a lockable global control register
- registered read data with a valid strobe
- a single aggregated interrupt output

---
 rtl/filter_csr_pkg.sv | 59 +++++
 rtl/filter_csr_bank_if.sv | 13 +
 rtl/filter_csr_bank_int_status_byte.sv | 54 +++++
 rtl/filter_csr_bank.sv | 198 +++++++++++++++++++
 tb/tb_filter_csr_bank.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_csr_pkg.sv
// Shared definitions for the filter CSR bank: CTRL field layout, GLOBAL bits,
// address-region decode type and address-map helpers derived from N.
package filter_csr_pkg;

   localparam int CTRL_TYPE_LSB   = 0;
   localparam int CTRL_TYPE_W     = 2;
   localparam int CTRL_WIN_LSB    = 2;
   localparam int CTRL_WIN_W      = 4;
   localparam int CTRL_INT_EN_BIT = 6;
   localparam int CTRL_WD_RST_BIT = 7;

   localparam int GLB_LOCK_BIT    = 0;
   localparam int GLB_IRQ_EN_BIT  = 1;

   typedef enum logic [2:0] {
      REG_CTRL   = 3'd0,
      REG_STATUS = 3'd1,
      REG_MASK   = 3'd2,
      REG_OVF    = 3'd3,
      REG_GLOBAL = 3'd4,
      REG_ID     = 3'd5,
      REG_NONE   = 3'd6
   } region_e;

   function automatic int num_bytes(input int n);
      return (n + 7) / 8;
   endfunction

   function automatic int status_base(input int n);
      return n;
   endfunction

   function automatic int mask_base(input int n);
      return n + num_bytes(n);
   endfunction

   function automatic int ovf_base(input int n);
      return n + 2 * num_bytes(n);
   endfunction

   function automatic int global_addr(input int n);
      return n + 3 * num_bytes(n);
   endfunction

   function automatic int id_addr(input int n);
      return global_addr(n) + 1;
   endfunction

   // Bits of byte-group k that map to an existing channel.
   function automatic logic [7:0] byte_valid_mask(input int n, input int k);
      logic [7:0] m;
      m = 8'h00;
      for (int b = 0; b < 8; b++) begin
         m[b] = ((8 * k + b) < n);
      end
      return m;
   endfunction

endpackage

// File: rtl/filter_csr_bank_if.sv
// Byte-wide register access bus between a host and the filter CSR bank.
interface filter_csr_bank_if #(parameter int ADDR_SIZE = 8);
   logic                 acc_en;
   logic                 wr_en;
   logic [ADDR_SIZE-1:0] addr;
   logic [7:0]           wdata;
   logic [7:0]           rdata;
   logic                 rvalid;
   logic                 wr_err;

   modport master (output acc_en, wr_en, addr, wdata, input rdata, rvalid, wr_err);
   modport slave  (input acc_en, wr_en, addr, wdata, output rdata, rvalid, wr_err);
endinterface

// File: rtl/filter_csr_bank_int_status_byte.sv
// One 8-channel group of interrupt STATUS / OVF / MASK registers with
// W1C clearing (set wins) and a pending flag for unmasked status.
module int_status_byte
   import filter_csr_pkg::*;
#(
   parameter logic [7:0] VALID_MASK = 8'hFF
)(
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic [7:0] ev_i,
   input  logic [7:0] st_w1c_i,
   input  logic [7:0] ovf_w1c_i,
   input  logic       mask_we_i,
   input  logic [7:0] mask_wdata_i,
   output logic [7:0] status_o,
   output logic [7:0] ovf_o,
   output logic [7:0] mask_o,
   output logic       pending_o
);

   logic [7:0] status_q, status_d;
   logic [7:0] ovf_q, ovf_d;
   logic [7:0] mask_q, mask_d;

   // Next state: events override a same-cycle clear; overflow uses pre-edge status.
   always_comb begin
      status_d = ((status_q & ~st_w1c_i) | ev_i) & VALID_MASK;
      ovf_d    = ((ovf_q & ~ovf_w1c_i) | (ev_i & status_q)) & VALID_MASK;
      if (mask_we_i) begin
         mask_d = mask_wdata_i & VALID_MASK;
      end else begin
         mask_d = mask_q;
      end
   end

   // Group register state with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         status_q <= 8'h00;
         ovf_q    <= 8'h00;
         mask_q   <= 8'h00;
      end else begin
         status_q <= status_d;
         ovf_q    <= ovf_d;
         mask_q   <= mask_d;
      end
   end

   assign status_o  = status_q;
   assign ovf_o     = ovf_q;
   assign mask_o    = mask_q;
   assign pending_o = |(status_q & ~mask_q);

endmodule

// File: rtl/filter_csr_bank.sv
// Configuration/status register bank for an N-channel input filter array:
// per-channel CTRL, W1C interrupt status, sticky overflow, masks, lockable GLOBAL.
module filter_csr_bank
   import filter_csr_pkg::*;
#(
   parameter int         N         = 8,
   parameter int         ADDR_SIZE = 8,
   parameter logic [7:0] VERSION   = 8'h02
)(
   input  logic             clk_i,
   input  logic             rstn_i,
   filter_csr_bank_if.slave bus,
   output logic [2*N-1:0]   filter_type_o,
   output logic [4*N-1:0]   window_size_o,
   output logic [N-1:0]     int_en_o,
   output logic [N-1:0]     wd_rst_o,
   input  logic [N-1:0]     in_int_i,
   output logic             irq_o
);

   localparam int S    = num_bytes(N);
   localparam int EV_W = 8 * S;
   localparam int STATUS_BASE = status_base(N);
   localparam int MASK_BASE   = mask_base(N);
   localparam int OVF_BASE    = ovf_base(N);
   localparam int GLOBAL_ADDR = global_addr(N);
   localparam int ID_ADDR     = id_addr(N);

   logic [ADDR_SIZE-1:0] addr_s;
   logic [31:0]          addr_w;
   logic [31:0]          idx_s;
   region_e              region_s;
   logic                 wr_s, rd_s;

   logic [7:0] ctrl_q [N];
   logic [7:0] ctrl_d [N];
   logic       lock_q, lock_d;
   logic       irq_en_q, irq_en_d;
   logic [7:0] rdata_q, rdata_d;
   logic       rvalid_q, rvalid_d;
   logic       wr_err_q, wr_err_d;
   logic       irq_q, irq_d;
   logic [7:0] rd_mux_s;

   logic [EV_W-1:0] ev_pad_s, st_w1c_s, ovf_w1c_s, status_s, ovf_s, mask_s;
   logic [S-1:0]    mask_we_s, pending_s;

   assign addr_s   = bus.addr;
   assign addr_w   = 32'(addr_s);
   assign wr_s     = bus.acc_en & bus.wr_en;
   assign rd_s     = bus.acc_en & ~bus.wr_en;
   assign ev_pad_s = EV_W'(in_int_i);

   // Address decode into register region and index within that region.
   always_comb begin
      region_s = REG_NONE;
      idx_s    = 32'h0;
      if (addr_w < 32'(STATUS_BASE)) begin
         region_s = REG_CTRL;
         idx_s    = addr_w;
      end else if (addr_w < 32'(MASK_BASE)) begin
         region_s = REG_STATUS;
         idx_s    = addr_w - 32'(STATUS_BASE);
      end else if (addr_w < 32'(OVF_BASE)) begin
         region_s = REG_MASK;
         idx_s    = addr_w - 32'(MASK_BASE);
      end else if (addr_w < 32'(GLOBAL_ADDR)) begin
         region_s = REG_OVF;
         idx_s    = addr_w - 32'(OVF_BASE);
      end else if (addr_w == 32'(GLOBAL_ADDR)) begin
         region_s = REG_GLOBAL;
      end else if (addr_w == 32'(ID_ADDR)) begin
         region_s = REG_ID;
      end else begin
         region_s = REG_NONE;
      end
   end

   for (genvar k = 0; k < S; k++) begin : g_byte
      assign st_w1c_s[8*k +: 8]  = (wr_s && (region_s == REG_STATUS) && (idx_s == 32'(k))) ? bus.wdata : 8'h00;
      assign ovf_w1c_s[8*k +: 8] = (wr_s && (region_s == REG_OVF) && (idx_s == 32'(k))) ? bus.wdata : 8'h00;
      assign mask_we_s[k]        = wr_s && (region_s == REG_MASK) && (idx_s == 32'(k));

      int_status_byte #(.VALID_MASK(byte_valid_mask(N, k))) u_isb (
         .clk_i        (clk_i),
         .rstn_i       (rstn_i),
         .ev_i         (ev_pad_s[8*k +: 8]),
         .st_w1c_i     (st_w1c_s[8*k +: 8]),
         .ovf_w1c_i    (ovf_w1c_s[8*k +: 8]),
         .mask_we_i    (mask_we_s[k]),
         .mask_wdata_i (bus.wdata),
         .status_o     (status_s[8*k +: 8]),
         .ovf_o        (ovf_s[8*k +: 8]),
         .mask_o       (mask_s[8*k +: 8]),
         .pending_o    (pending_s[k])
      );
   end

   // Read data multiplexer over the whole address map.
   always_comb begin
      rd_mux_s = 8'h00;
      case (region_s)
         REG_CTRL: begin
            for (int i = 0; i < N; i++) begin
               if (idx_s == 32'(i)) rd_mux_s = ctrl_q[i];
               else                 rd_mux_s = rd_mux_s;
            end
         end
         REG_STATUS, REG_MASK, REG_OVF: begin
            for (int k = 0; k < S; k++) begin
               if (idx_s == 32'(k)) begin
                  if (region_s == REG_STATUS)    rd_mux_s = status_s[8*k +: 8];
                  else if (region_s == REG_MASK) rd_mux_s = mask_s[8*k +: 8];
                  else                           rd_mux_s = ovf_s[8*k +: 8];
               end else begin
                  rd_mux_s = rd_mux_s;
               end
            end
         end
         REG_GLOBAL: begin
            rd_mux_s[GLB_LOCK_BIT]   = lock_q;
            rd_mux_s[GLB_IRQ_EN_BIT] = irq_en_q;
         end
         REG_ID:   rd_mux_s = VERSION;
         default:  rd_mux_s = 8'h00;
      endcase
   end

   // Write handling, read capture and interrupt aggregation.
   always_comb begin
      ctrl_d   = ctrl_q;
      lock_d   = lock_q;
      irq_en_d = irq_en_q;
      wr_err_d = 1'b0;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      irq_d    = irq_en_q & (|pending_s);
      if (wr_s) begin
         case (region_s)
            REG_CTRL: begin
               if (lock_q) begin
                  wr_err_d = 1'b1;
               end else begin
                  for (int i = 0; i < N; i++) begin
                     if (idx_s == 32'(i)) ctrl_d[i] = bus.wdata;
                     else                 ctrl_d[i] = ctrl_q[i];
                  end
               end
            end
            REG_GLOBAL: begin
               lock_d   = lock_q | bus.wdata[GLB_LOCK_BIT];
               irq_en_d = bus.wdata[GLB_IRQ_EN_BIT];
            end
            REG_ID, REG_NONE: wr_err_d = 1'b1;
            default:          wr_err_d = 1'b0;
         endcase
      end else if (rd_s) begin
         rdata_d  = rd_mux_s;
         rvalid_d = 1'b1;
      end else begin
         rvalid_d = 1'b0;
      end
   end

   // Bank register state with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < N; i++) ctrl_q[i] <= 8'h00;
         lock_q   <= 1'b0;
         irq_en_q <= 1'b0;
         rdata_q  <= 8'h00;
         rvalid_q <= 1'b0;
         wr_err_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         lock_q   <= lock_d;
         irq_en_q <= irq_en_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         wr_err_q <= wr_err_d;
         irq_q    <= irq_d;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_ch
      assign filter_type_o[2*i +: 2] = ctrl_q[i][CTRL_TYPE_LSB +: CTRL_TYPE_W];
      assign window_size_o[4*i +: 4] = ctrl_q[i][CTRL_WIN_LSB +: CTRL_WIN_W];
      assign int_en_o[i]             = ctrl_q[i][CTRL_INT_EN_BIT];
      assign wd_rst_o[i]             = ctrl_q[i][CTRL_WD_RST_BIT];
   end

   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;
   assign bus.wr_err = wr_err_q;
   assign irq_o      = irq_q;

endmodule

// File: tb/tb_filter_csr_bank.sv
// Self-checking bench for filter_csr_bank (N=8): directed scenarios plus
// randomized traffic against a register-map level reference model.
module tb_filter_csr_bank;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  in_int;
   logic [15:0] filter_type;
   logic [31:0] window_size;
   logic [7:0]  int_en, wd_rst;
   logic        irq;
   int          errors = 0;
   int          checks = 0;

   // reference model state (N=8: STATUS@8 MASK@9 OVF@10 GLOBAL@11 ID@12)
   logic [7:0] m_ctrl [8];
   logic [7:0] m_status, m_mask, m_ovf, m_rdata;
   logic       m_lock, m_irq_en, m_irq, m_rvalid, m_wrerr;

   filter_csr_bank_if #(.ADDR_SIZE(8)) bus ();

   filter_csr_bank #(.N(8), .ADDR_SIZE(8), .VERSION(8'h02)) dut (
      .clk_i         (clk),
      .rstn_i        (rstn),
      .bus           (bus),
      .filter_type_o (filter_type),
      .window_size_o (window_size),
      .int_en_o      (int_en),
      .wd_rst_o      (wd_rst),
      .in_int_i      (in_int),
      .irq_o         (irq)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] m_read(input logic [7:0] a);
      if (a < 8'd8)        return m_ctrl[a[2:0]];
      else if (a == 8'd8)  return m_status;
      else if (a == 8'd9)  return m_mask;
      else if (a == 8'd10) return m_ovf;
      else if (a == 8'd11) return {6'b0, m_irq_en, m_lock};
      else if (a == 8'd12) return 8'h02;
      else                 return 8'h00;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_ctrl[i] = 8'h00;
      m_status = 8'h00; m_mask = 8'h00; m_ovf = 8'h00; m_rdata = 8'h00;
      m_lock = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0; m_rvalid = 1'b0; m_wrerr = 1'b0;
   endtask

   task automatic model_update(input logic acc, input logic wr, input logic [7:0] a,
                               input logic [7:0] wd, input logic [7:0] ev);
      logic [7:0] st_clr, ovf_clr, old_status;
      logic       next_irq;
      st_clr = 8'h00; ovf_clr = 8'h00;
      old_status = m_status;
      next_irq = m_irq_en && ((m_status & ~m_mask) != 8'h00);
      m_rvalid = 1'b0;
      m_wrerr  = 1'b0;
      if (acc && !wr) begin
         m_rdata  = m_read(a);
         m_rvalid = 1'b1;
      end
      if (acc && wr) begin
         if (a < 8'd8) begin
            if (m_lock) m_wrerr = 1'b1;
            else        m_ctrl[a[2:0]] = wd;
         end else if (a == 8'd8)  st_clr = wd;
         else if (a == 8'd9)  m_mask = wd;
         else if (a == 8'd10) ovf_clr = wd;
         else if (a == 8'd11) begin
            m_lock   = m_lock | wd[0];
            m_irq_en = wd[1];
         end else m_wrerr = 1'b1;
      end
      m_status = (m_status & ~st_clr) | ev;
      m_ovf    = (m_ovf & ~ovf_clr) | (ev & old_status);
      m_irq    = next_irq;
   endtask

   // One clock: drive, advance model with the edge, sample 1 time unit later.
   task automatic step(input logic acc, input logic wr, input logic [7:0] a,
                       input logic [7:0] wd, input logic [7:0] ev);
      bus.acc_en = acc; bus.wr_en = wr; bus.addr = a; bus.wdata = wd; in_int = ev;
      @(posedge clk);
      model_update(acc, wr, a, wd, ev);
      #1;
      bus.acc_en = 1'b0; bus.wr_en = 1'b0; in_int = 8'h00;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic v);
      step(1'b1, 1'b0, a, 8'h00, 8'h00);
      d = bus.rdata;
      v = bus.rvalid;
   endtask

   task automatic test_reset();
      logic [7:0] d; logic v; logic [7:0] e;
      rstn = 1'b0;
      bus.acc_en = 1'b1; bus.wr_en = 1'b1; bus.addr = 8'd0; bus.wdata = 8'hFF; in_int = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      bus.acc_en = 1'b0; bus.wr_en = 1'b0; in_int = 8'h00;
      model_reset();
      checks++;
      if ({bus.rdata, bus.rvalid, bus.wr_err, irq} !== 11'h000) begin
         errors++; $display("FAIL reset_outputs got %h exp 000", {bus.rdata, bus.rvalid, bus.wr_err, irq});
      end
      for (int a = 0; a <= 14; a++) begin
         rd(8'(a), d, v);
         e = (a == 12) ? 8'h02 : 8'h00;
         checks++;
         if (d !== e || v !== 1'b1) begin
            errors++; $display("FAIL reset_read addr=%0d got %h/%b exp %h/1", a, d, v, e);
         end
      end
      rd(8'd12, d, v);
      step(1'b0, 1'b0, 8'd0, 8'h00, 8'h00);
      checks++;
      if (bus.rvalid !== 1'b0 || bus.rdata !== 8'h02 || irq !== 1'b0) begin
         errors++; $display("FAIL rvalid_pulse_hold got %b/%h/%b exp 0/02/0", bus.rvalid, bus.rdata, irq);
      end
   endtask

   task automatic test_ctrl();
      logic [7:0] d; logic v;
      logic [15:0] et; logic [31:0] ew; logic [7:0] ei, ed;
      step(1'b1, 1'b1, 8'd3, 8'hC9, 8'h00);
      checks++;
      if (filter_type[7:6] !== 2'b01 || window_size[15:12] !== 4'h2 || int_en[3] !== 1'b1 ||
          wd_rst[3] !== 1'b1 || bus.wr_err !== 1'b0) begin
         errors++; $display("FAIL ctrl3_fields got %b %h %b %b err=%b exp 01 2 1 1 err=0",
                            filter_type[7:6], window_size[15:12], int_en[3], wd_rst[3], bus.wr_err);
      end
      rd(8'd3, d, v);
      checks++;
      if (d !== 8'hC9 || v !== 1'b1) begin
         errors++; $display("FAIL ctrl3_readback got %h/%b exp c9/1", d, v);
      end
      for (int n = 0; n < 12; n++) step(1'b1, 1'b1, 8'($urandom_range(0, 7)), 8'($urandom), 8'h00);
      for (int i = 0; i < 8; i++) begin
         et[2*i +: 2] = m_ctrl[i][1:0];
         ew[4*i +: 4] = m_ctrl[i][5:2];
         ei[i] = m_ctrl[i][6];
         ed[i] = m_ctrl[i][7];
      end
      checks++;
      if (filter_type !== et || window_size !== ew || int_en !== ei || wd_rst !== ed) begin
         errors++; $display("FAIL ctrl_random_fields got %h %h %h %h exp %h %h %h %h",
                            filter_type, window_size, int_en, wd_rst, et, ew, ei, ed);
      end
   endtask

   task automatic test_irq();
      logic [7:0] d; logic v;
      step(1'b1, 1'b1, 8'd11, 8'h02, 8'h00);
      step(1'b0, 1'b0, 8'd0, 8'h00, 8'h20);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_t1 got %b exp 0", irq); end
      step(1'b0, 1'b0, 8'd0, 8'h00, 8'h00);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_t2 got %b exp 1", irq); end
      rd(8'd8, d, v);
      checks++;
      if (d !== 8'h20) begin errors++; $display("FAIL status_bit5 got %h exp 20", d); end
      step(1'b1, 1'b1, 8'd8, 8'h20, 8'h00);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_at_w1c got %b exp 1", irq); end
      step(1'b0, 1'b0, 8'd0, 8'h00, 8'h00);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_w1c got %b exp 0", irq); end
      rd(8'd8, d, v);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL status_cleared got %h exp 00", d); end
   endtask

   task automatic test_ovf();
      logic [7:0] d; logic v;
      step(1'b0, 1'b0, 8'd0, 8'h00, 8'h04);
      step(1'b0, 1'b0, 8'd0, 8'h00, 8'h04);
      rd(8'd8, d, v);
      checks++;
      if (d !== 8'h04) begin errors++; $display("FAIL ovf_status got %h exp 04", d); end
      rd(8'd10, d, v);
      checks++;
      if (d !== 8'h04) begin errors++; $display("FAIL ovf_set got %h exp 04", d); end
      step(1'b1, 1'b1, 8'd8, 8'h04, 8'h04);
      rd(8'd8, d, v);
      checks++;
      if (d !== 8'h04) begin errors++; $display("FAIL set_wins_status got %h exp 04", d); end
      step(1'b1, 1'b1, 8'd10, 8'h04, 8'h00);
      rd(8'd10, d, v);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL ovf_w1c got %h exp 00", d); end
      step(1'b1, 1'b1, 8'd8, 8'hFF, 8'h00);
      step(1'b0, 1'b0, 8'd0, 8'h00, 8'h00);
      checks++;
      if (irq !== m_irq) begin errors++; $display("FAIL ovf_irq got %b exp %b", irq, m_irq); end
   endtask

   task automatic test_mask();
      logic [7:0] d; logic v;
      step(1'b1, 1'b1, 8'd9, 8'hFF, 8'h00);
      step(1'b0, 1'b0, 8'd0, 8'h00, 8'h01);
      rd(8'd8, d, v);
      checks++;
      if (d !== 8'h01) begin errors++; $display("FAIL masked_status got %h exp 01", d); end
      step(1'b0, 1'b0, 8'd0, 8'h00, 8'h00);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq got %b exp 0", irq); end
      step(1'b1, 1'b1, 8'd9, 8'h00, 8'h00);
      step(1'b0, 1'b0, 8'd0, 8'h00, 8'h00);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL unmasked_irq got %b exp 1", irq); end
      step(1'b1, 1'b1, 8'd8, 8'h01, 8'h00);
   endtask

   task automatic test_random();
      logic acc, wr; logic [7:0] a, wd, ev;
      logic [15:0] et;
      for (int n = 0; n < 400; n++) begin
         acc = ($urandom_range(0, 3) != 0);
         wr  = 1'($urandom);
         a   = 8'($urandom_range(0, 14));
         wd  = 8'($urandom);
         if (a == 8'd11) wd[0] = 1'b0;
         ev  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         step(acc, wr, a, wd, ev);
         for (int i = 0; i < 8; i++) et[2*i +: 2] = m_ctrl[i][1:0];
         checks++;
         if (bus.rvalid !== m_rvalid || bus.rdata !== m_rdata || bus.wr_err !== m_wrerr ||
             irq !== m_irq || filter_type !== et) begin
            errors++;
            $display("FAIL random cyc=%0d got v=%b d=%h e=%b i=%b t=%h exp v=%b d=%h e=%b i=%b t=%h",
                     n, bus.rvalid, bus.rdata, bus.wr_err, irq, filter_type,
                     m_rvalid, m_rdata, m_wrerr, m_irq, et);
         end
      end
   endtask

   task automatic test_lock();
      logic [7:0] d; logic v;
      step(1'b1, 1'b1, 8'd0, 8'hAA, 8'h00);
      step(1'b1, 1'b1, 8'd11, 8'h01, 8'h00);
      step(1'b1, 1'b1, 8'd0, 8'h55, 8'h00);
      checks++;
      if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL locked_wr_err got %b exp 1", bus.wr_err); end
      step(1'b0, 1'b0, 8'd0, 8'h00, 8'h00);
      checks++;
      if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_pulse got %b exp 0", bus.wr_err); end
      rd(8'd0, d, v);
      checks++;
      if (d !== 8'hAA) begin errors++; $display("FAIL locked_ctrl got %h exp aa", d); end
      step(1'b1, 1'b1, 8'd11, 8'h00, 8'h00);
      rd(8'd11, d, v);
      checks++;
      if (d !== 8'h01) begin errors++; $display("FAIL lock_sticky got %h exp 01", d); end
      step(1'b1, 1'b1, 8'h80, 8'h12, 8'h00);
      checks++;
      if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL unmapped_wr_err got %b exp 1", bus.wr_err); end
      step(1'b1, 1'b1, 8'd12, 8'h34, 8'h00);
      checks++;
      if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL id_wr_err got %b exp 1", bus.wr_err); end
      rd(8'd12, d, v);
      checks++;
      if (d !== 8'h02) begin errors++; $display("FAIL id_value got %h exp 02", d); end
   endtask

   initial begin
      bus.acc_en = 1'b0; bus.wr_en = 1'b0; bus.addr = 8'h00; bus.wdata = 8'h00;
      in_int = 8'h00; rstn = 1'b0;
      model_reset();
      test_reset();
      test_ctrl();
      test_irq();
      test_ovf();
      test_mask();
      test_random();
      test_lock();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

endmodule
